// File: rtl/pll_ctrl_pkg.sv
// Shared types and helpers for the GW1N PLL reconfiguration sequencer.
package pll_ctrl_pkg;

  localparam int SEL_W_DEF = 6;

  typedef enum logic [2:0] {
    PRST      = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  typedef struct packed {
    logic [SEL_W_DEF-1:0] idsel;
    logic [SEL_W_DEF-1:0] fbdsel;
    logic [SEL_W_DEF-1:0] odsel;
  } sel_t;

  // One spare bit above the largest terminal count keeps the saturating compare simple.
  function automatic int cnt_w(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/pll_reconfig_ctrl_if.sv
// Configuration handshake between the LCD timing logic (master) and the PLL sequencer (slave).
interface pll_reconfig_ctrl_if import pll_ctrl_pkg::*; #(
  parameter int SEL_W = SEL_W_DEF
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [SEL_W-1:0] cfg_idsel;
  logic [SEL_W-1:0] cfg_fbdsel;
  logic [SEL_W-1:0] cfg_odsel;

  modport master (output cfg_valid, cfg_idsel, cfg_fbdsel, cfg_odsel, input cfg_ready);
  modport slave  (input cfg_valid, cfg_idsel, cfg_fbdsel, cfg_odsel, output cfg_ready);
endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop bit synchroniser with synchronous active-high reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/pll_reconfig_ctrl.sv
// PLL reconfiguration sequencer: applies an IDSEL/FBDSEL/ODSEL triple, resets the PLL, qualifies lock.
// Optional macro PLL_RETRY_EN: retry on lock timeout, then one last attempt on the DEF_* selects.
//
// state     | meaning
// PRST      | PLL held in reset for RESET_CYCLES
// WAIT_LOCK | reset released, waiting for lock_s (timeout LOCK_TIMEOUT)
// STABLE    | counting consecutive lock_s cycles up to LOCK_STABLE
// RUN       | clock qualified, new config accepted
// FAULT     | lock never came; PLL parked in reset, new config accepted
module pll_reconfig_ctrl import pll_ctrl_pkg::*; #(
  parameter int               SEL_W        = SEL_W_DEF,
  parameter logic [SEL_W-1:0] DEF_IDSEL    = '0,
  parameter logic [SEL_W-1:0] DEF_FBDSEL   = '0,
  parameter logic [SEL_W-1:0] DEF_ODSEL    = '0,
  parameter int               RESET_CYCLES = 16,
  parameter int               LOCK_TIMEOUT = 24000,
  parameter int               LOCK_STABLE  = 64,
  parameter int               MAX_RETRY    = 3
) (
  input  logic             clkin,
  input  logic             reset,
  pll_reconfig_ctrl_if.slave cfg,
  input  logic             pll_lock,
  output logic             pll_reset,
  output logic [SEL_W-1:0] pll_idsel,
  output logic [SEL_W-1:0] pll_fbdsel,
  output logic [SEL_W-1:0] pll_odsel,
  output logic             clk_ok,
  output logic             lock_lost,
  output logic             err_timeout
);

  if (SEL_W != SEL_W_DEF || RESET_CYCLES < 1 || LOCK_TIMEOUT < 1 || LOCK_STABLE < 1 || MAX_RETRY < 0)
  begin : g_param_check
    $error("pll_reconfig_ctrl: illegal parameter set");
  end

  localparam int               CNT_W    = cnt_w(RESET_CYCLES, LOCK_TIMEOUT, LOCK_STABLE);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE - 1);
  localparam sel_t             SEL_DEF  = '{idsel: DEF_IDSEL, fbdsel: DEF_FBDSEL, odsel: DEF_ODSEL};

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  sel_t             sel_q, sel_n;
  logic             lock_s, accept, ready_q;
  logic             pll_reset_n, clk_ok_n, ready_n, lost_n, err_n;

`ifdef PLL_RETRY_EN
  localparam int RTRY_W = $clog2(MAX_RETRY + 2);
  logic [RTRY_W-1:0] retry_q, retry_n;
`endif

  sync_2ff #(.RST_VAL(1'b0)) u_lock_sync (
    .clk   (clkin),
    .reset (reset),
    .d     (pll_lock),
    .q     (lock_s)
  );

  assign accept        = cfg.cfg_valid & ready_q;
  assign cfg.cfg_ready = ready_q;
  assign cnt_inc       = (cnt == '1) ? cnt : cnt + 1'b1;
  assign pll_idsel     = sel_q.idsel;
  assign pll_fbdsel    = sel_q.fbdsel;
  assign pll_odsel     = sel_q.odsel;

  always_comb begin
    state_n = state;
    cnt_n   = cnt_inc;
    sel_n   = sel_q;
    err_n   = err_timeout;
    lost_n  = 1'b0;
`ifdef PLL_RETRY_EN
    retry_n = retry_q;
`endif
    case (state)
      PRST: begin
        if (cnt >= RST_LAST) begin
          state_n = WAIT_LOCK;
          cnt_n   = '0;
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          // The qualifying lock_s sample counts as the first stable cycle.
          state_n = (LOCK_STABLE == 1) ? RUN : STABLE;
          cnt_n   = CNT_W'(1);
        end else if (cnt >= TMO_LAST) begin
          cnt_n = '0;
`ifdef PLL_RETRY_EN
          if (retry_q < RTRY_W'(MAX_RETRY)) begin
            retry_n = retry_q + 1'b1;
            state_n = PRST;
          end else if (retry_q == RTRY_W'(MAX_RETRY)) begin
            retry_n = retry_q + 1'b1;
            err_n   = 1'b1;
            sel_n   = SEL_DEF;
            state_n = PRST;
          end else begin
            err_n   = 1'b1;
            state_n = FAULT;
          end
`else
          err_n   = 1'b1;
          state_n = FAULT;
`endif
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_n = WAIT_LOCK;
          cnt_n   = '0;
        end else if (cnt >= STB_LAST) begin
          state_n = RUN;
          cnt_n   = '0;
        end
      end
      RUN: begin
        cnt_n = '0;
        if (!lock_s) begin
          state_n = WAIT_LOCK;
          lost_n  = 1'b1;
        end
      end
      FAULT:   cnt_n = '0;
      default: begin
        state_n = PRST;
        cnt_n   = '0;
      end
    endcase
    // A new request overrides whatever the lock monitor decided this cycle.
    if (accept) begin
      state_n = PRST;
      cnt_n   = '0;
      sel_n   = '{idsel: cfg.cfg_idsel, fbdsel: cfg.cfg_fbdsel, odsel: cfg.cfg_odsel};
      err_n   = 1'b0;
      lost_n  = 1'b0;
`ifdef PLL_RETRY_EN
      retry_n = '0;
`endif
    end
    pll_reset_n = (state_n == PRST) || (state_n == FAULT);
    clk_ok_n    = (state_n == RUN);
    ready_n     = (state_n == RUN) || (state_n == FAULT);
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      state       <= PRST;
      cnt         <= '0;
      sel_q       <= SEL_DEF;
      pll_reset   <= 1'b1;
      clk_ok      <= 1'b0;
      ready_q     <= 1'b0;
      lock_lost   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      sel_q       <= sel_n;
      pll_reset   <= pll_reset_n;
      clk_ok      <= clk_ok_n;
      ready_q     <= ready_n;
      lock_lost   <= lost_n;
      err_timeout <= err_n;
    end
  end

`ifdef PLL_RETRY_EN
  always_ff @(posedge clkin) begin
    if (reset) retry_q <= '0;
    else       retry_q <= retry_n;
  end
`endif

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Bench for pll_reconfig_ctrl with a simple PLL model: lock follows pll_up while PLL reset is low.
`timescale 1ns/1ps
module tb_pll_reconfig_ctrl;
  import pll_ctrl_pkg::*;

  localparam int LT = 100;

  typedef struct packed {
    logic [5:0] id;
    logic [5:0] fb;
    logic [5:0] od;
    logic       err;
  } exp_t;

  logic       clkin = 1'b0;
  logic       reset = 1'b1;
  logic       pll_up = 1'b1;
  logic       pll_lock;
  logic       pll_reset, clk_ok, lock_lost, err_timeout;
  logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
  int         total = 0;
  int         bad = 0;
  exp_t       exp_q[$];

  pll_reconfig_ctrl_if #(.SEL_W(6)) cfg ();

  always #5 clkin = ~clkin;
  assign pll_lock = pll_up & ~pll_reset;

  pll_reconfig_ctrl #(.LOCK_TIMEOUT(LT)) dut (
    .clkin       (clkin),
    .reset       (reset),
    .cfg         (cfg),
    .pll_lock    (pll_lock),
    .pll_reset   (pll_reset),
    .pll_idsel   (pll_idsel),
    .pll_fbdsel  (pll_fbdsel),
    .pll_odsel   (pll_odsel),
    .clk_ok      (clk_ok),
    .lock_lost   (lock_lost),
    .err_timeout (err_timeout)
  );

  task automatic offer(input logic [5:0] id, input logic [5:0] fb, input logic [5:0] od, input logic e);
    @(negedge clkin);
    cfg.cfg_valid  = 1'b1;
    cfg.cfg_idsel  = id;
    cfg.cfg_fbdsel = fb;
    cfg.cfg_odsel  = od;
    exp_q.push_back('{id, fb, od, e});
    @(negedge clkin);
    cfg.cfg_valid = 1'b0;
  endtask

  task automatic count_reset_high(output int n);
    n = 0;
    while (pll_reset === 1'b1 && n < 400) begin
      n++;
      @(negedge clkin);
    end
  endtask

  task automatic wait_clk_ok(output int n, output int lost, output int rst);
    n = 0; lost = 0; rst = 0;
    while (clk_ok !== 1'b1 && n < 400) begin
      @(negedge clkin);
      n++;
      if (lock_lost === 1'b1) lost++;
      if (pll_reset === 1'b1) rst++;
    end
  endtask

  task automatic test_reset;
    exp_t e;
    int n, lost, rst;
    reset = 1'b1;
    pll_up = 1'b1;
    exp_q.push_back('{6'd0, 6'd0, 6'd0, 1'b0});
    repeat (3) @(negedge clkin);
    e = exp_q.pop_front();
    total++; if (pll_reset !== 1'b1) begin bad++; $display("FAIL reset_pll_reset: got %0b want 1", pll_reset); end
    total++; if ({pll_idsel, pll_fbdsel, pll_odsel} !== {e.id, e.fb, e.od}) begin bad++; $display("FAIL reset_sel: got %0d/%0d/%0d want %0d/%0d/%0d", pll_idsel, pll_fbdsel, pll_odsel, e.id, e.fb, e.od); end
    total++; if (clk_ok !== 1'b0) begin bad++; $display("FAIL reset_clk_ok: got %0b want 0", clk_ok); end
    total++; if (cfg.cfg_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %0b want 0", cfg.cfg_ready); end
    total++; if (lock_lost !== 1'b0 || err_timeout !== 1'b0) begin bad++; $display("FAIL reset_flags: got %0b%0b want 00", lock_lost, err_timeout); end
    reset = 1'b0;
    count_reset_high(n);
    total++; if (n != 16) begin bad++; $display("FAIL reset_prst_len: got %0d want 16", n); end
    wait_clk_ok(n, lost, rst);
    total++; if (n != 66) begin bad++; $display("FAIL reset_lock_time: got %0d want 66", n); end
    total++; if (cfg.cfg_ready !== 1'b1) begin bad++; $display("FAIL reset_run_ready: got %0b want 1", cfg.cfg_ready); end
  endtask

  task automatic test_reconfig;
    exp_t e;
    int n, lost, rst;
    total++; if (cfg.cfg_ready !== 1'b1) begin bad++; $display("FAIL recfg_ready_before: got %0b want 1", cfg.cfg_ready); end
    offer(6'd3, 6'd24, 6'd4, 1'b0);
    e = exp_q.pop_front();
    total++; if ({pll_idsel, pll_fbdsel, pll_odsel} !== {e.id, e.fb, e.od}) begin bad++; $display("FAIL recfg_sel: got %0d/%0d/%0d want %0d/%0d/%0d", pll_idsel, pll_fbdsel, pll_odsel, e.id, e.fb, e.od); end
    total++; if ({pll_reset, clk_ok, cfg.cfg_ready} !== 3'b100) begin bad++; $display("FAIL recfg_outputs: got rst/ok/rdy=%b want 100", {pll_reset, clk_ok, cfg.cfg_ready}); end
    count_reset_high(n);
    total++; if (n != 16) begin bad++; $display("FAIL recfg_prst_len: got %0d want 16", n); end
    wait_clk_ok(n, lost, rst);
    total++; if (n != 66) begin bad++; $display("FAIL recfg_lock_time: got %0d want 66", n); end
    total++; if ({pll_idsel, pll_fbdsel, pll_odsel} !== {6'd3, 6'd24, 6'd4}) begin bad++; $display("FAIL recfg_sel_hold: got %0d/%0d/%0d want 3/24/4", pll_idsel, pll_fbdsel, pll_odsel); end
  endtask

  task automatic test_lock_drop;
    int n, lost, rst, lost0, rst0;
    lost0 = 0; rst0 = 0;
    pll_up = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clkin);
      if (lock_lost === 1'b1) lost0++;
      if (pll_reset === 1'b1) rst0++;
    end
    total++; if (clk_ok !== 1'b0) begin bad++; $display("FAIL drop_clk_ok: got %0b want 0", clk_ok); end
    pll_up = 1'b1;
    wait_clk_ok(n, lost, rst);
    total++; if (lost0 + lost != 1) begin bad++; $display("FAIL drop_lost_pulses: got %0d want 1", lost0 + lost); end
    total++; if (rst0 + rst != 0) begin bad++; $display("FAIL drop_pll_reset: got %0d want 0", rst0 + rst); end
    total++; if (n != 66) begin bad++; $display("FAIL drop_relock_time: got %0d want 66", n); end
  endtask

  task automatic test_accept_vs_loss;
    exp_t e;
    int n, lost, rst;
    total++; if (clk_ok !== 1'b1) begin bad++; $display("FAIL avl_precond: got %0b want 1", clk_ok); end
    pll_up = 1'b0;
    repeat (2) @(negedge clkin);
    cfg.cfg_valid  = 1'b1;
    cfg.cfg_idsel  = 6'd1;
    cfg.cfg_fbdsel = 6'd2;
    cfg.cfg_odsel  = 6'd3;
    exp_q.push_back('{6'd1, 6'd2, 6'd3, 1'b0});
    @(negedge clkin);
    cfg.cfg_valid = 1'b0;
    e = exp_q.pop_front();
    total++; if (lock_lost !== 1'b0) begin bad++; $display("FAIL avl_lock_lost: got %0b want 0", lock_lost); end
    total++; if (pll_reset !== 1'b1) begin bad++; $display("FAIL avl_pll_reset: got %0b want 1", pll_reset); end
    total++; if ({pll_idsel, pll_fbdsel, pll_odsel} !== {e.id, e.fb, e.od}) begin bad++; $display("FAIL avl_sel: got %0d/%0d/%0d want %0d/%0d/%0d", pll_idsel, pll_fbdsel, pll_odsel, e.id, e.fb, e.od); end
    pll_up = 1'b1;
    count_reset_high(n);
    total++; if (n != 16) begin bad++; $display("FAIL avl_prst_len: got %0d want 16", n); end
    wait_clk_ok(n, lost, rst);
    total++; if (lost != 0 || n != 66) begin bad++; $display("FAIL avl_relock: got lost=%0d time=%0d want lost=0 time=66", lost, n); end
  endtask

  task automatic test_stable_glitch;
    exp_t e;
    int n, lost, rst;
    offer(6'd5, 6'd10, 6'd2, 1'b0);
    e = exp_q.pop_front();
    total++; if ({pll_idsel, pll_fbdsel, pll_odsel} !== {e.id, e.fb, e.od}) begin bad++; $display("FAIL glitch_sel: got %0d/%0d/%0d want %0d/%0d/%0d", pll_idsel, pll_fbdsel, pll_odsel, e.id, e.fb, e.od); end
    count_reset_high(n);
    repeat (33) @(negedge clkin);
    total++; if (clk_ok !== 1'b0) begin bad++; $display("FAIL glitch_precond: got %0b want 0", clk_ok); end
    pll_up = 1'b0;
    @(negedge clkin);
    pll_up = 1'b1;
    wait_clk_ok(n, lost, rst);
    total++; if (n != 66) begin bad++; $display("FAIL glitch_restart: got %0d want 66", n); end
  endtask

  task automatic test_timeout;
    exp_t e;
    int n, lost, rst;
    pll_up = 1'b0;
    offer(6'd7, 6'd7, 6'd7, 1'b0);
    e = exp_q.pop_front();
    total++; if ({pll_idsel, pll_fbdsel, pll_odsel, err_timeout} !== {e.id, e.fb, e.od, e.err}) begin bad++; $display("FAIL tmo_accept: got %0d/%0d/%0d err=%0b want %0d/%0d/%0d err=%0b", pll_idsel, pll_fbdsel, pll_odsel, err_timeout, e.id, e.fb, e.od, e.err); end
    count_reset_high(n);
    n = 0;
    while (err_timeout !== 1'b1 && n < 400) begin
      @(negedge clkin);
      n++;
    end
    total++; if (n != LT) begin bad++; $display("FAIL tmo_cycles: got %0d want %0d", n, LT); end
    repeat (5) @(negedge clkin);
    total++; if ({cfg.cfg_ready, pll_reset, clk_ok, err_timeout} !== 4'b1101) begin bad++; $display("FAIL tmo_fault: got rdy/rst/ok/err=%b want 1101", {cfg.cfg_ready, pll_reset, clk_ok, err_timeout}); end
    pll_up = 1'b1;
    offer(6'd2, 6'd3, 6'd4, 1'b0);
    e = exp_q.pop_front();
    total++; if (err_timeout !== e.err) begin bad++; $display("FAIL tmo_err_clear: got %0b want %0b", err_timeout, e.err); end
    count_reset_high(n);
    wait_clk_ok(n, lost, rst);
    total++; if (n != 66) begin bad++; $display("FAIL tmo_recover: got %0d want 66", n); end
  endtask

  task automatic test_retry;
    exp_t e;
    int n, lost, rst, pulses;
    logic prev;
    pll_up = 1'b0;
    offer(6'd9, 6'd8, 6'd7, 1'b0);
    for (int i = 0; i < 3; i++) exp_q.push_back('{6'd9, 6'd8, 6'd7, 1'b0});
    exp_q.push_back('{6'd0, 6'd0, 6'd0, 1'b1});
    pulses = 0; prev = 1'b0; n = 0;
    while (cfg.cfg_ready !== 1'b1 && n < 3000) begin
      if (pll_reset === 1'b1 && prev !== 1'b1) begin
        pulses++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          total++; if ({pll_idsel, pll_fbdsel, pll_odsel, err_timeout} !== {e.id, e.fb, e.od, e.err}) begin bad++; $display("FAIL retry_pulse%0d: got %0d/%0d/%0d err=%0b want %0d/%0d/%0d err=%0b", pulses, pll_idsel, pll_fbdsel, pll_odsel, err_timeout, e.id, e.fb, e.od, e.err); end
        end
      end
      prev = pll_reset;
      @(negedge clkin);
      n++;
    end
    total++; if (pulses != 5) begin bad++; $display("FAIL retry_pulse_count: got %0d want 5", pulses); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL retry_queue_left: got %0d want 0", exp_q.size()); end
    total++; if ({pll_reset, clk_ok, err_timeout} !== 3'b101) begin bad++; $display("FAIL retry_fault: got rst/ok/err=%b want 101", {pll_reset, clk_ok, err_timeout}); end
    exp_q.delete();
    pll_up = 1'b1;
    offer(6'd2, 6'd3, 6'd4, 1'b0);
    e = exp_q.pop_front();
    total++; if (err_timeout !== e.err) begin bad++; $display("FAIL retry_err_clear: got %0b want %0b", err_timeout, e.err); end
    count_reset_high(n);
    wait_clk_ok(n, lost, rst);
    total++; if (n != 66) begin bad++; $display("FAIL retry_recover: got %0d want 66", n); end
  endtask

  initial begin
    cfg.cfg_valid  = 1'b0;
    cfg.cfg_idsel  = '0;
    cfg.cfg_fbdsel = '0;
    cfg.cfg_odsel  = '0;
    test_reset();
    test_reconfig();
    test_lock_drop();
    test_accept_vs_loss();
    test_stable_glitch();
`ifdef PLL_RETRY_EN
    test_retry();
`else
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
